// File: rtl/clock_domain_importer.sv
// clock_domain_importer
//
// Receiving half of a toggle-handshake clock-domain crossing. A word is
// pending whenever the synchronised request toggle differs from the local
// ack toggle. It is captured into a small FIFO when there is room, and
// capturing it toggles the ack. The FIFO drains to local logic over a
// valid/ready stream, so consumer stalls do not hold up the ack unless the
// FIFO is full.
//
// Parameters:
//   pBits   width of the transferred word (must match the exporter)
//   pDepth  FIFO depth in words, power of two, 2..256
//
// Ports:
//   clk        destination-domain clock
//   rst_n      asynchronous active-low reset
//   cd_req     request toggle from exporter (asynchronous to clk)
//   cd_data    bundled data; stable while cd_req is unchanged
//   cd_ack     ack toggle back to exporter (registered)
//   out_valid  FIFO non-empty
//   out_data   word at FIFO head (combinational read)
//   out_ready  consumer takes the head word this cycle
//   level      current FIFO occupancy
//
// Optional build macro CLOCK_DOMAIN_IMPORTER_STATS_EN adds:
//   xfer_count 16-bit wrapping count of captured words
//   stall      registered flag: a word was pending but the FIFO was full
//              at the previous edge

module clock_domain_importer #(
    parameter int unsigned pBits  = 8,
    parameter int unsigned pDepth = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cd_req,
    input  logic [pBits-1:0]          cd_data,
    output logic                      cd_ack,
    output logic                      out_valid,
    output logic [pBits-1:0]          out_data,
    input  logic                      out_ready,
`ifdef CLOCK_DOMAIN_IMPORTER_STATS_EN
    output logic [15:0]               xfer_count,
    output logic                      stall,
`endif
    output logic [$clog2(pDepth):0]   level
);

    localparam int unsigned AW = $clog2(pDepth);
    localparam int unsigned PW = AW + 1;

    // Synchroniser, ack toggle and pointers
    logic [1:0]    req_sync_q, req_sync_d;
    logic          ack_q, ack_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;

    // Storage is deliberately left out of reset
    logic [pBits-1:0] mem_q [pDepth];

    logic req_s;
    logic pending;
    logic empty;
    logic full;
    logic push;
    logic pop;

    assign req_s   = req_sync_q[1];
    assign pending = req_s ^ ack_q;
    assign empty   = (wr_ptr_q == rd_ptr_q);
    // Wrap bits differ and index bits match: writer is a whole lap ahead
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // Full blocks push even if a pop happens this cycle; push resumes the
    // cycle after the pop
    assign push    = pending && !full;
    assign pop     = !empty && out_ready;

    always_comb begin
        req_sync_d = {req_sync_q[0], cd_req};
        ack_d      = ack_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push) begin
            ack_d    = ~ack_q;
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_sync_q <= 2'b00;
            ack_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            req_sync_q <= req_sync_d;
            ack_q      <= ack_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // cd_data is only sampled here, two or more clocks after req moved
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= cd_data;
        end
    end

    assign cd_ack    = ack_q;
    assign out_valid = !empty;
    assign out_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign level     = wr_ptr_q - rd_ptr_q;

`ifdef CLOCK_DOMAIN_IMPORTER_STATS_EN
    logic [15:0] xfer_count_q, xfer_count_d;
    logic        stall_q, stall_d;

    always_comb begin
        xfer_count_d = xfer_count_q;
        if (push) begin
            xfer_count_d = xfer_count_q + 16'd1;
        end
        stall_d = pending && full;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_count_q <= 16'd0;
            stall_q      <= 1'b0;
        end else begin
            xfer_count_q <= xfer_count_d;
            stall_q      <= stall_d;
        end
    end

    assign xfer_count = xfer_count_q;
    assign stall      = stall_q;
`endif

endmodule

// File: tb/tb_clock_domain_importer.sv
// Directed bench for clock_domain_importer (pBits=8, pDepth=4). The bench
// plays the exporter: it toggles cd_req with a new word whenever the
// previous word has been acknowledged, and checks consumed words against
// the order in which they were sent.

module tb_clock_domain_importer;

    logic       clk;
    logic       rst_n;
    logic       cd_req;
    logic [7:0] cd_data;
    logic       cd_ack;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [2:0] level;
`ifdef CLOCK_DOMAIN_IMPORTER_STATS_EN
    logic [15:0] xfer_count;
    logic        stall;
`endif

    clock_domain_importer #(
        .pBits  (8),
        .pDepth (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cd_req     (cd_req),
        .cd_data    (cd_data),
        .cd_ack     (cd_ack),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
`ifdef CLOCK_DOMAIN_IMPORTER_STATS_EN
        .xfer_count (xfer_count),
        .stall      (stall),
`endif
        .level      (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks;
    int unsigned n_fail;
    int unsigned ack_toggles;
    int unsigned rx_cnt;
    int unsigned stall_highs;
    logic        ack_prev;
    logic [7:0]  tx_q [$];
    logic [7:0]  exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: consume head if a pop is about to happen, act as the
    // exporter, then advance past the edge and record ack/stall activity.
    task automatic tick();
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            n_checks++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL rx_extra: observed word %0h expected none", out_data);
            end
            if (exp_q.size() != 0) begin
                chk("rx_order", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
            end
            rx_cnt++;
        end
        if (tx_q.size() != 0 && cd_req == cd_ack) begin
            cd_data = tx_q.pop_front();
            cd_req  = ~cd_req;
            exp_q.push_back(cd_data);
        end
        @(posedge clk);
        #1;
        if (cd_ack !== ack_prev) ack_toggles++;
        ack_prev = cd_ack;
`ifdef CLOCK_DOMAIN_IMPORTER_STATS_EN
        if (stall === 1'b1) stall_highs++;
`endif
    endtask

    initial begin
        int guard;
        n_checks    = 0;
        n_fail      = 0;
        ack_toggles = 0;
        rx_cnt      = 0;
        stall_highs = 0;
        ack_prev    = 1'b0;
        rst_n       = 1'b0;
        cd_req      = 1'b0;
        cd_data     = 8'h00;
        out_ready   = 1'b0;

        // Reset state
        #12;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_level", {29'd0, level}, 32'd0);
        chk("rst_ack", {31'd0, cd_ack}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single transfer: ack moves on the 3rd edge after req toggles
        out_ready = 1'b1;
        cd_data   = 8'hA5;
        cd_req    = 1'b1;
        exp_q.push_back(8'hA5);
        tick();
        chk("single_e0_ack", {31'd0, cd_ack}, 32'd0);
        chk("single_e0_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("single_e1_ack", {31'd0, cd_ack}, 32'd0);
        chk("single_e1_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("single_e2_ack", {31'd0, cd_ack}, 32'd1);
        chk("single_e2_valid", {31'd0, out_valid}, 32'd1);
        chk("single_e2_data", {24'd0, out_data}, 32'h0000_00A5);
        chk("single_e2_level", {29'd0, level}, 32'd1);
        tick();
        chk("single_e3_valid", {31'd0, out_valid}, 32'd0);
        chk("single_e3_level", {29'd0, level}, 32'd0);
        chk("single_rx", rx_cnt, 32'd1);

        // Back-to-back: 16 words, consumer always ready
        ack_toggles = 0;
        rx_cnt      = 0;
        for (int i = 1; i <= 16; i++) tx_q.push_back(8'(i));
        guard = 0;
        while (rx_cnt < 16 && guard < 400) begin
            tick();
            guard++;
        end
        for (int i = 0; i < 5; i++) tick();
        chk("b2b_rx", rx_cnt, 32'd16);
        chk("b2b_acks", ack_toggles, 32'd16);
        chk("b2b_empty", {31'd0, out_valid}, 32'd0);

        // Backpressure: 6 words into a 4-deep FIFO with consumer stalled
        out_ready   = 1'b0;
        ack_toggles = 0;
        rx_cnt      = 0;
        for (int i = 0; i < 6; i++) tx_q.push_back(8'h31 + 8'(i));
        guard = 0;
        while (ack_toggles < 4 && guard < 100) begin
            tick();
            guard++;
        end
        for (int i = 0; i < 10; i++) tick();
        chk("bp_level_sat", {29'd0, level}, 32'd4);
        chk("bp_acks_sat", ack_toggles, 32'd4);
        chk("bp_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_head_hold", {24'd0, out_data}, 32'h0000_0031);
        out_ready = 1'b1;
        tick();
        chk("bp_pop1_level", {29'd0, level}, 32'd3);
        chk("bp_pop1_acks", ack_toggles, 32'd4);
        tick();
        chk("bp_push5_acks", ack_toggles, 32'd5);
        chk("bp_push5_level", {29'd0, level}, 32'd3);
        guard = 0;
        while (rx_cnt < 6 && guard < 100) begin
            tick();
            guard++;
        end
        chk("bp_rx", rx_cnt, 32'd6);
        chk("bp_acks", ack_toggles, 32'd6);
        chk("bp_level_end", {29'd0, level}, 32'd0);

        // Simultaneous push and pop at level 2
        out_ready   = 1'b0;
        ack_toggles = 0;
        rx_cnt      = 0;
        tx_q.push_back(8'h51);
        tx_q.push_back(8'h52);
        tx_q.push_back(8'h53);
        guard = 0;
        while (ack_toggles < 2 && guard < 100) begin
            tick();
            guard++;
        end
        chk("sim_level2", {29'd0, level}, 32'd2);
        tick();
        tick();
        chk("sim_pre_acks", ack_toggles, 32'd2);
        out_ready = 1'b1;
        tick();
        chk("sim_level_kept", {29'd0, level}, 32'd2);
        chk("sim_acks", ack_toggles, 32'd3);
        guard = 0;
        while (rx_cnt < 3 && guard < 50) begin
            tick();
            guard++;
        end
        chk("sim_rx", rx_cnt, 32'd3);

        // Asynchronous reset with level 3
        out_ready   = 1'b0;
        ack_toggles = 0;
        for (int i = 0; i < 3; i++) tx_q.push_back(8'h70 + 8'(i));
        guard = 0;
        while (ack_toggles < 3 && guard < 100) begin
            tick();
            guard++;
        end
        chk("ar_level3", {29'd0, level}, 32'd3);
        chk("ar_ack_pre", {31'd0, cd_ack}, 32'd1);
        #2;
        rst_n  = 1'b0;
        cd_req = 1'b0;
        #1;
        chk("ar_valid_now", {31'd0, out_valid}, 32'd0);
        chk("ar_level_now", {29'd0, level}, 32'd0);
        chk("ar_ack_now", {31'd0, cd_ack}, 32'd0);
        #3;
        rst_n       = 1'b1;
        ack_prev    = 1'b0;
        ack_toggles = 0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) tick();
        chk("ar_post_level", {29'd0, level}, 32'd0);
        chk("ar_post_ack", {31'd0, cd_ack}, 32'd0);
        chk("ar_post_acks", ack_toggles, 32'd0);

`ifdef CLOCK_DOMAIN_IMPORTER_STATS_EN
        // Statistics: 20 transfers with a 4-cycle stall at full
        chk("st_count_rst", {16'd0, xfer_count}, 32'd0);
        chk("st_stall_rst", {31'd0, stall}, 32'd0);
        ack_toggles = 0;
        rx_cnt      = 0;
        stall_highs = 0;
        for (int i = 0; i < 20; i++) tx_q.push_back(8'h90 + 8'(i));
        guard = 0;
        while (ack_toggles < 4 && guard < 100) begin
            tick();
            guard++;
        end
        tick();
        chk("st_stall_a", {31'd0, stall}, 32'd0);
        tick();
        chk("st_stall_b", {31'd0, stall}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("st_stall_held", {31'd0, stall}, 32'd1);
        end
        out_ready = 1'b1;
        tick();
        chk("st_stall_pop", {31'd0, stall}, 32'd1);
        tick();
        chk("st_stall_clear", {31'd0, stall}, 32'd0);
        guard = 0;
        while (rx_cnt < 20 && guard < 400) begin
            tick();
            guard++;
        end
        for (int i = 0; i < 5; i++) tick();
        chk("st_rx", rx_cnt, 32'd20);
        chk("st_count", {16'd0, xfer_count}, 32'd20);
        chk("st_stall_cycles", stall_highs, 32'd5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
